muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide sequencer owning the HI/LO registers of the 5-stage MIPS core.
//  Accepts mult/multu/div/divu from EX and runs a WIDTH-cycle shift-add / restoring-divide engine.
//  Drives pipeline-hold controls for two cases:
//   - structural: a second muldiv op arrives while the engine is busy;
//   - data: mfhi/mflo in DEC while HI/LO are pending.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  Clk        in   1      clock, all state on rising edge
//  Reset      in   1      synchronous, active-high
//  Start_EX   in   1      mult/multu/div/divu valid in EX
//  Op_EX      in   2      00 mult, 01 multu, 10 div, 11 divu
//  A_EX       in   WIDTH  rs operand (multiplicand / dividend)
//  B_EX       in   WIDTH  rt operand (multiplier / divisor)
//  MtHi_EX    in   1      mthi in EX
//  MtLo_EX    in   1      mtlo in EX
//  MfHiLo_DEC in   1      mfhi or mflo in DEC
//  HI, LO     out  WIDTH  architectural HI/LO (registered)
//  Busy       out  1      engine not IDLE
//  Done       out  1      1-cycle pulse on the edge HI/LO take a muldiv result
//  DivZero    out  1      1-cycle pulse alongside Done for div/divu with B=0
//  PC_write   out  1      0 = hold PC
//  IFID_write out  1      0 = hold IF/ID
//  IDEX_write out  1      0 = hold ID/EX
//  stall_IDEX out  1      1 = bubble into ID/EX
//  stall_EXMEM out 1      1 = bubble into EX/MEM
// BEHAVIOUR
//  Reset value of every output: HI=LO=0, Busy=Done=DivZero=0, PC_write=IFID_write=IDEX_write=1,
//   stall_IDEX=stall_EXMEM=0. Reset mid-operation aborts the op, clears the counter, returns to IDLE.
//  FSM:
//   - IDLE -> MUL/DIV on Start_EX (edge t): latch |A|,|B| (signed ops) or A,B (unsigned), record
//     sign flags, counter = WIDTH.
//   - MUL/DIV: one iteration per cycle, counter decrements; at counter==1 go to FIX.
//   - FIX: apply sign correction, write HI/LO, pulse Done, -> IDLE.
//   - Latency: Start at edge t -> HI/LO hold result after edge t+WIDTH+1; Busy=1 for WIDTH+1 cycles.
//  Arithmetic:
//   - mult/multu: {HI,LO} = 2*WIDTH-bit product; signed product negated when sign(A)!=sign(B).
//   - div/divu: LO = quotient, HI = remainder.
//   - Signed divide: quotient truncates toward zero, negated if signs differ; remainder takes
//     sign of A.
//   - B==0: no iterations (DIV->FIX after one cycle regardless), HI=A, LO={WIDTH{1}}, DivZero=1.
//     Latency 2 cycles.
//   - Signed MIN_INT/-1: LO=MIN_INT, HI=0 (natural wrap, no flag).
//  mthi/mtlo:
//   - In IDLE without Start_EX: write HI/LO from A_EX at the edge.
//   - Same cycle as Start_EX: Start wins, mt ignored (software hazard).
//  Hold rules, combinational, priority order:
//   1. Structural: (Start_EX|MtHi_EX|MtLo_EX) && Busy -> PC_write=0, IFID_write=0,
//      IDEX_write=0, stall_EXMEM=1. Op is accepted on the first edge after return to IDLE.
//   2. Data: MfHiLo_DEC && (Busy || Start_EX accepted this cycle) -> PC_write=0, IFID_write=0,
//      stall_IDEX=1.
//   3. Otherwise all hold outputs at reset values.
//  FIX cycle counts as Busy: mfhi is released the cycle after Done, reading the new HI/LO.
//  Done and a new Start are never in the same cycle (Start blocked while Busy).
// TESTING
//  1. mult A=-3 (FFFFFFFD), B=7 -> after 33 cycles HI=FFFFFFFF, LO=FFFFFFEB; Done pulses once.
//  2. divu A=100, B=7 -> LO=14, HI=2.
//     div A=-7, B=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//  3. div A=5, B=0 -> 2 cycles later HI=5, LO=FFFFFFFF, DivZero=1 coincident with Done.
//  4. multu then mflo in next slot -> stall_IDEX=1, PC_write=0 for exactly 33 cycles, mflo reads
//     new LO.
//  5. Back-to-back mult,mult -> second held in EX (IDEX_write=0, stall_EXMEM=1) 33 cycles, then
//     both results correct.
//  6. Reset asserted at iteration 10 -> next cycle Busy=0, HI=LO=0, all hold outputs released;
//     new op runs correctly.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns HI/LO.
// One shift-add (mult) or restoring-divide (div) step per cycle, magnitude
// arithmetic with a final sign-correction cycle, plus the pipeline hold
// controls for structural (engine busy) and data (mfhi/mflo) hazards.
//
// Handshake: Start_EX (and MtHi_EX/MtLo_EX) act as "valid" from EX; the
// engine is "ready" exactly when Busy is 0. An op transfers on a rising edge
// where valid && ready; while valid && !ready the hold outputs freeze the
// front of the pipeline, so the op stays presented until it is accepted.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start_EX,
  input  logic [1:0]       Op_EX,
  input  logic [WIDTH-1:0] A_EX,
  input  logic [WIDTH-1:0] B_EX,
  input  logic             MtHi_EX,
  input  logic             MtLo_EX,
  input  logic             MfHiLo_DEC,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             stall_IDEX,
  output logic             stall_EXMEM,
  output logic [1:0]       dbgState
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hiAcc, loAcc, bReg;   // working product/remainder, multiplier/quotient, mcand/divisor
  logic [WIDTH-1:0] hiReg, loReg;         // architectural HI/LO
  logic             negQ;                 // product or quotient must be negated
  logic             negR;                 // remainder must be negated (dividend was negative)
  logic             isDivOp;
  logic             divZeroOp;

  // Operand conditioning: signed ops work on magnitudes
  logic             isSigned, aNeg, bNeg;
  logic [WIDTH-1:0] aMag, bMag;

  // One-step datapath results
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] prod, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // Operand sign handling and per-step arithmetic
  always_comb begin
    isSigned = ~Op_EX[0];
    aNeg     = isSigned & A_EX[WIDTH-1];
    bNeg     = isSigned & B_EX[WIDTH-1];
    aMag     = aNeg ? -A_EX : A_EX;
    bMag     = bNeg ? -B_EX : B_EX;
    mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, bReg} : {(WIDTH+1){1'b0}});
    divTrial = {hiAcc, loAcc[WIDTH-1]} - {1'b0, bReg};
    prod     = {hiAcc, loAcc};
    prodFix  = negQ ? -prod : prod;
    quotFix  = negQ ? -loAcc : loAcc;
    remFix   = negR ? -hiAcc : hiAcc;
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE: if (Start_EX) stateNext = Op_EX[1] ? S_DIV : S_MUL;
      S_MUL:  if (count == CNT_ONE) stateNext = S_FIX;
      S_DIV:  if (divZeroOp || count == CNT_ONE) stateNext = S_FIX;
      S_FIX:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iterations, sign fix and HI/LO writes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count     <= '0;
      hiAcc     <= '0;
      loAcc     <= '0;
      bReg      <= '0;
      hiReg     <= '0;
      loReg     <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      isDivOp   <= 1'b0;
      divZeroOp <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start_EX) begin
            // mult: loAcc holds the multiplier, bReg the multiplicand
            // div:  loAcc holds the dividend,   bReg the divisor
            hiAcc     <= '0;
            loAcc     <= Op_EX[1] ? aMag : bMag;
            bReg      <= Op_EX[1] ? bMag : aMag;
            count     <= CNT_INIT;
            negQ      <= aNeg ^ bNeg;
            negR      <= aNeg;
            isDivOp   <= Op_EX[1];
            divZeroOp <= Op_EX[1] && (B_EX == '0);
          end else begin
            // mthi/mtlo only take effect when no muldiv starts this cycle
            if (MtHi_EX) hiReg <= A_EX;
            if (MtLo_EX) loReg <= A_EX;
          end
        end
        S_MUL: begin
          {hiAcc, loAcc} <= {mulSum, loAcc[WIDTH-1:1]};
          count          <= count - CNT_ONE;
        end
        S_DIV: begin
          if (divZeroOp) begin
            // No iterations: remainder is the dividend; sign fix restores A
            hiAcc <= loAcc;
            loAcc <= '1;
            count <= '0;
          end else begin
            if (!divTrial[WIDTH]) begin
              hiAcc <= divTrial[WIDTH-1:0];
              loAcc <= {loAcc[WIDTH-2:0], 1'b1};
            end else begin
              hiAcc <= {hiAcc[WIDTH-2:0], loAcc[WIDTH-1]};
              loAcc <= {loAcc[WIDTH-2:0], 1'b0};
            end
            count <= count - CNT_ONE;
          end
        end
        S_FIX: begin
          if (isDivOp) begin
            hiReg <= remFix;
            loReg <= divZeroOp ? {WIDTH{1'b1}} : quotFix;
          end else begin
            {hiReg, loReg} <= prodFix;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs and pipeline hold controls (structural beats data)
  always_comb begin
    HI          = hiReg;
    LO          = loReg;
    Busy        = (state != S_IDLE);
    Done        = (state == S_FIX);
    DivZero     = (state == S_FIX) && isDivOp && divZeroOp;
    dbgState    = state;
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    stall_IDEX  = 1'b0;
    stall_EXMEM = 1'b0;
    if ((Start_EX || MtHi_EX || MtLo_EX) && Busy) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      stall_EXMEM = 1'b1;
    end else if (MfHiLo_DEC && (Busy || Start_EX)) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      stall_IDEX = 1'b1;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed + random checks of muldiv_ctrl against a plain
// arithmetic reference model (64-bit products, truncating / and %).
module tb_muldiv_ctrl;

  localparam int WIDTH = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_ex;
  logic [1:0]        op_ex;
  logic [WIDTH-1:0]  a_ex, b_ex;
  logic              mthi_ex, mtlo_ex, mfhilo_dec;
  logic [WIDTH-1:0]  hi, lo;
  logic              busy, done, divzero;
  logic              pc_write, ifid_write, idex_write, stall_idex, stall_exmem;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [2*WIDTH-1:0] exp_q[$];

  muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .Clk(clk), .Reset(reset), .Start_EX(start_ex), .Op_EX(op_ex),
    .A_EX(a_ex), .B_EX(b_ex), .MtHi_EX(mthi_ex), .MtLo_EX(mtlo_ex),
    .MfHiLo_DEC(mfhilo_dec), .HI(hi), .LO(lo), .Busy(busy), .Done(done),
    .DivZero(divzero), .PC_write(pc_write), .IFID_write(ifid_write),
    .IDEX_write(idex_write), .stall_IDEX(stall_idex),
    .stall_EXMEM(stall_exmem), .dbgState(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural operands
  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e_dz = 1'b0;
    case (op)
      2'b00: begin sp = sa * sb; e_hi = sp[63:32]; e_lo = sp[31:0]; end
      2'b01: begin up = ua * ub; e_hi = up[63:32]; e_lo = up[31:0]; end
      default: begin
        if (b == 0) begin
          e_hi = a; e_lo = '1; e_dz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb; sr = sa % sb;
          e_lo = sq[31:0]; e_hi = sr[31:0];
        end else begin
          up = ua / ub; e_lo = up[31:0];
          up = ua % ub; e_hi = up[31:0];
        end
      end
    endcase
  endtask

  task automatic idle_inputs();
    start_ex = 0; op_ex = 0; a_ex = 0; b_ex = 0;
    mthi_ex = 0; mtlo_ex = 0; mfhilo_dec = 0;
  endtask

  // Count busy cycles until the engine returns to idle (bounded)
  task automatic wait_busy(input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                           output int busy_n, output int done_n, output int dz_n,
                           output int dz_done, output int early, output int stall_n);
    int guard = 0;
    busy_n = 0; done_n = 0; dz_n = 0; dz_done = 0; early = 0; stall_n = 0;
    while (busy && guard < 200) begin
      busy_n++; guard++;
      if (done) done_n++;
      if (divzero) dz_n++;
      if (divzero && done) dz_done++;
      if (hi !== pre_hi || lo !== pre_lo) early++;
      if (stall_idex && !pc_write && !ifid_write) stall_n++;
      @(negedge clk); #1;
    end
  endtask

  // Driver: one muldiv op, optional mfhi/mflo behind it, optional mt in same slot
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mf, input logic mt);
    logic [31:0] eh, el, pre_hi, pre_lo;
    logic        edz;
    int          exp_lat, busy_n, done_n, dz_n, dz_done, early, stall_n;
    ref_model(op, a, b, eh, el, edz);
    exp_q.push_back({eh, el});
    exp_lat = (op[1] && b == 0) ? 2 : WIDTH + 1;
    @(negedge clk);
    start_ex = 1; op_ex = op; a_ex = a; b_ex = b;
    mfhilo_dec = mf; mthi_ex = mt; mtlo_ex = mt;
    #1;
    check("start_ready", {63'b0, busy}, 64'd0);
    if (mf) check("start_data_hold", {62'b0, stall_idex, pc_write}, 64'b10);
    pre_hi = hi; pre_lo = lo;
    @(negedge clk);
    start_ex = 0; mthi_ex = 0; mtlo_ex = 0; a_ex = $urandom; b_ex = $urandom;
    #1;
    wait_busy(pre_hi, pre_lo, busy_n, done_n, dz_n, dz_done, early, stall_n);
    check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    check("done_pulses", 64'(done_n), 64'd1);
    check("divzero", {32'(dz_n), 32'(dz_done)}, {32'(edz), 32'(edz)});
    check("hilo_early", 64'(early), 64'd0);
    check("mf_stall_cycles", 64'(stall_n), mf ? 64'(exp_lat) : 64'd0);
    check("result", {hi, lo}, exp_q.pop_front());
    if (mf) check("mf_release", {62'b0, stall_idex, pc_write}, 64'b01);
    mfhilo_dec = 0;
  endtask

  // Driver: back-to-back ops, second one held in EX until the first finishes
  task automatic do_b2b(input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2);
    logic [31:0] eh, el, pre_hi, pre_lo;
    logic        edz;
    int          held, guard, busy_n, done_n, dz_n, dz_done, early, stall_n;
    ref_model(op1, a1, b1, eh, el, edz);
    exp_q.push_back({eh, el});
    ref_model(op2, a2, b2, eh, el, edz);
    exp_q.push_back({eh, el});
    @(negedge clk);
    start_ex = 1; op_ex = op1; a_ex = a1; b_ex = b1;
    @(negedge clk);
    op_ex = op2; a_ex = a2; b_ex = b2;
    #1;
    held = 0; guard = 0;
    while (busy && guard < 200) begin
      guard++;
      if (!idex_write && stall_exmem && !pc_write && !ifid_write && !stall_idex) held++;
      @(negedge clk); #1;
    end
    check("struct_hold_cycles", 64'(held), 64'(WIDTH + 1));
    check("struct_release", {59'b0, pc_write, ifid_write, idex_write, stall_idex, stall_exmem},
          64'b11100);
    check("b2b_first", {hi, lo}, exp_q.pop_front());
    pre_hi = hi; pre_lo = lo;
    @(negedge clk);
    start_ex = 0;
    #1;
    wait_busy(pre_hi, pre_lo, busy_n, done_n, dz_n, dz_done, early, stall_n);
    check("b2b_second_busy", 64'(busy_n), 64'(WIDTH + 1));
    check("b2b_second", {hi, lo}, exp_q.pop_front());
  endtask

  logic [31:0] rnd_a, rnd_b, mt_val;
  logic [31:0] specials[4];

  initial begin
    // Reset block
    idle_inputs();
    reset = 1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_status", {61'b0, busy, done, divzero}, 64'd0);
    check("reset_holds", {59'b0, pc_write, ifid_write, idex_write, stall_idex, stall_exmem},
          64'b11100);
    reset = 0;

    // Directed: spec examples
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    check("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_neg7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    check("div_by_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("div_minint", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    do_op(2'b10, 32'h8000_0005, 32'd0, 1'b1, 1'b0);
    do_b2b(2'b00, 32'd12345, 32'hFFFF_FF00, 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // mthi / mtlo in idle
    mt_val = $urandom;
    @(negedge clk);
    mthi_ex = 1; a_ex = mt_val;
    #1;
    check("mt_no_hold", {63'b0, pc_write}, 64'd1);
    @(negedge clk);
    mthi_ex = 0; mtlo_ex = 1; a_ex = ~mt_val;
    #1;
    check("mthi", {32'b0, hi}, {32'b0, mt_val});
    @(negedge clk);
    mtlo_ex = 0;
    #1;
    check("mtlo", {32'b0, lo}, {32'b0, ~mt_val});

    // Reset in the middle of an op
    @(negedge clk);
    start_ex = 1; op_ex = 2'b01; a_ex = 32'hDEAD_BEEF; b_ex = 32'h1234_5678;
    @(negedge clk);
    start_ex = 0;
    repeat (10) @(negedge clk);
    reset = 1; mfhilo_dec = 1; start_ex = 1; op_ex = 2'b00;
    @(negedge clk);
    reset = 0; start_ex = 0;
    #1;
    check("abort_busy", {62'b0, busy, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_holds", {59'b0, pc_write, ifid_write, idex_write, stall_idex, stall_exmem},
          64'b11100);
    mfhilo_dec = 0;
    do_op(2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b0);

    // Random ops, operands mixed with boundary values
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 30; i++) begin
      rnd_a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      rnd_b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 2) == 0) rnd_b = rnd_b >> $urandom_range(0, 31);
      do_op(2'($urandom_range(0, 3)), rnd_a, rnd_b, 1'($urandom_range(0, 1)), 1'b0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
